fifo_dual_ctrl: RTL

- Pointer and flag controller for the team's asymmetric FIFO.
- Each write pushes two entries; each read pops one.
- Drives the register file's write enable, its two write addresses (low half, high half) and its read address.
- Produces full, empty, occupancy and sticky error flags for the producer and consumer.

---
 rtl/fifo_dual_ctrl.sv | 82 ++++++++
 1 files changed

// File: rtl/fifo_dual_ctrl.sv
// Pointer and flag controller for an asymmetric FIFO: each accepted write
// stores two entries, each accepted read removes one.
module fifo_dual_ctrl #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr0,
  output logic [ADDR_WIDTH-1:0] w_addr1,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ovf,
  output logic                  udf
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_THR = (ADDR_WIDTH + 1)'(DEPTH - 2);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic                  wr_acc, rd_acc;

  // Full means there is no room for a complete two-entry word.
  assign empty = (count_q == '0);
  assign full  = (count_q > FULL_THR);

  assign wr_acc = wr & ~full;
  assign rd_acc = rd & ~empty;

  assign w_en    = wr_acc;
  assign w_addr0 = wr_ptr_q;
  assign w_addr1 = wr_ptr_q + ADDR_WIDTH'(1);
  assign r_addr  = rd_ptr_q;
  assign count   = count_q;
  assign ovf     = ovf_q;
  assign udf     = udf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (wr & full);
    udf_d    = udf_q | (rd & empty);
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(2);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(2);
      2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
      2'b11:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

endmodule
